// File: rtl/range_ascii_framer.sv
`default_nettype none
// ============================================================================
// Module   : range_ascii_framer
// Purpose  : Converts a 16-bit range measurement to decimal ASCII with a
//            sequential double-dabble and streams it, optionally followed by
//            CR LF, through a UART enable/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module range_ascii_framer #(
  parameter logic SUPPRESS_ZEROS = 1'b1,
  parameter logic SEND_CRLF      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] distance,
  input  logic        distance_valid,
  input  logic        tx_done,
  output logic        tx_enable,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONVERT   = 3'd1,
    S_SELECT    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  // Byte slots 0..4 carry digits 4..0 (most significant first), slot 5 is CR
  // and slot 6 is LF. A frame runs from its first slot up to c_last_slot.
  localparam logic [2:0] c_last_slot = SEND_CRLF ? 3'd6 : 3'd4;
  localparam logic [4:0] c_last_iter = 5'd15;

  state_t      r_state, w_state_next;
  logic [15:0] r_bin, w_bin_next;
  logic [19:0] r_bcd, w_bcd_next;
  logic [4:0]  r_iter, w_iter_next;
  logic [2:0]  r_slot, w_slot_next;
  logic        r_tx_enable, w_tx_enable_next;
  logic [7:0]  r_tx_data, w_tx_data_next;

  logic [19:0] w_adj;
  logic [35:0] w_shift;
  logic [2:0]  w_first_digit;

  // ASCII byte carried by a given slot of the current frame.
  function automatic logic [7:0] slot_byte(input logic [2:0] slot, input logic [19:0] bcd);
    logic [3:0] nib;
    nib = 4'h0;
    case (slot)
      3'd0:    nib = bcd[19:16];
      3'd1:    nib = bcd[15:12];
      3'd2:    nib = bcd[11:8];
      3'd3:    nib = bcd[7:4];
      default: nib = bcd[3:0];
    endcase
    if (slot < 3'd5)       slot_byte = 8'h30 + {4'h0, nib};
    else if (slot == 3'd5) slot_byte = 8'h0D;
    else                   slot_byte = 8'h0A;
  endfunction

  // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_shift = {w_adj, r_bin} << 1;
  end

  // First digit to send: highest nonzero nibble, or always digit 4 when padding.
  always_comb begin
    w_first_digit = 3'd0;
    if (!SUPPRESS_ZEROS) begin
      w_first_digit = 3'd4;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_bcd[4*i +: 4] != 4'd0) w_first_digit = 3'(i);
      end
    end
  end

  // Next-state and datapath update for the framing sequencer.
  always_comb begin
    w_state_next     = r_state;
    w_bin_next       = r_bin;
    w_bcd_next       = r_bcd;
    w_iter_next      = r_iter;
    w_slot_next      = r_slot;
    w_tx_enable_next = r_tx_enable;
    w_tx_data_next   = r_tx_data;
    case (r_state)
      // FINISH behaves like IDLE for acceptance because busy is already low.
      S_IDLE, S_FINISH: begin
        w_state_next = S_IDLE;
        if (distance_valid) begin
          w_bin_next   = distance;
          w_bcd_next   = '0;
          w_iter_next  = '0;
          w_slot_next  = '0;
          w_state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        w_bcd_next = w_shift[35:16];
        w_bin_next = w_shift[15:0];
        if (r_iter == c_last_iter) w_state_next = S_SELECT;
        else                       w_iter_next  = r_iter + 5'd1;
      end
      S_SELECT: begin
        w_slot_next      = 3'd4 - w_first_digit;
        w_tx_data_next   = slot_byte(3'd4 - w_first_digit, r_bcd);
        w_tx_enable_next = 1'b1;
        w_state_next     = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (r_tx_enable && tx_done) begin
          w_tx_enable_next = 1'b0;
          w_state_next     = (r_slot == c_last_slot) ? S_FINISH : S_GAP;
        end
      end
      S_GAP: begin
        w_slot_next      = r_slot + 3'd1;
        w_tx_data_next   = slot_byte(r_slot + 3'd1, r_bcd);
        w_tx_enable_next = 1'b1;
        w_state_next     = S_WAIT_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_iter      <= '0;
      r_slot      <= '0;
      r_tx_enable <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_bin       <= w_bin_next;
      r_bcd       <= w_bcd_next;
      r_iter      <= w_iter_next;
      r_slot      <= w_slot_next;
      r_tx_enable <= w_tx_enable_next;
      r_tx_data   <= w_tx_data_next;
    end
  end

  assign tx_enable  = r_tx_enable;
  assign tx_data    = r_tx_data;
  assign busy       = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign frame_done = (r_state == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_range_ascii_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_range_ascii_framer
// Purpose  : Self-checking bench for range_ascii_framer with a UART model
//            that answers each accepted byte with tx_done 10 cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_ascii_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] distance = 16'd0;
  logic        distance_valid = 1'b0;
  logic        distance_valid_nz = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_done_nz = 1'b0;
  logic        tx_enable, busy, frame_done;
  logic [7:0]  tx_data;
  logic        tx_enable_nz, busy_nz, frame_done_nz;
  logic [7:0]  tx_data_nz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  byte unsigned rx[$];
  int rise[$];
  int fd_count = 0;
  int unstable = 0;
  int busy_at_fd = 0;
  byte unsigned rx_nz[$];
  int fd_nz = 0;
  bit spurious_req = 1'b0;

  range_ascii_framer #(.SUPPRESS_ZEROS(1'b1), .SEND_CRLF(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .distance(distance), .distance_valid(distance_valid),
    .tx_done(tx_done), .tx_enable(tx_enable), .tx_data(tx_data), .busy(busy),
    .frame_done(frame_done)
  );

  range_ascii_framer #(.SUPPRESS_ZEROS(1'b0), .SEND_CRLF(1'b1)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .distance(distance), .distance_valid(distance_valid_nz),
    .tx_done(tx_done_nz), .tx_enable(tx_enable_nz), .tx_data(tx_data_nz), .busy(busy_nz),
    .frame_done(frame_done_nz)
  );

  always #5 clk = ~clk;

  // Cycle number: counts rising edges.
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model and observer for the main instance (samples on falling edge).
  initial begin : tx_model
    int pend;
    byte unsigned held;
    pend = 0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (spurious_req) begin
        tx_done = 1'b1;
        spurious_req = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) tx_done = 1'b1;
      end else if (tx_enable) begin
        rx.push_back(tx_data);
        rise.push_back(cyc);
        held = tx_data;
        pend = 10;
      end
      if (tx_enable && tx_data !== held) unstable++;
      if (frame_done) begin
        fd_count++;
        if (busy) busy_at_fd++;
      end
    end
  end

  // Transmitter model for the zero-padding instance.
  initial begin : tx_model_nz
    int pend_nz;
    pend_nz = 0;
    forever begin
      @(negedge clk);
      tx_done_nz = 1'b0;
      if (pend_nz > 0) begin
        pend_nz--;
        if (pend_nz == 0) tx_done_nz = 1'b1;
      end else if (tx_enable_nz) begin
        rx_nz.push_back(tx_data_nz);
        pend_nz = 10;
      end
      if (frame_done_nz) fd_nz++;
    end
  end

  // Reference: the decimal text of d (padded to 5 digits if not suppressing) plus CR LF.
  function automatic string model_frame(input int unsigned d, input bit suppress);
    string s;
    s = $sformatf("%0d", d);
    if (!suppress) while (s.len() < 5) s = {"0", s};
    return {s, "\r\n"};
  endfunction

  function automatic string s_hex(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
    return r;
  endfunction

  function automatic string q_hex(input byte unsigned q[$]);
    string r;
    r = "";
    foreach (q[i]) r = {r, $sformatf("%02h ", q[i])};
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] d);
    distance = d;
    distance_valid = 1'b1;
    acc_cyc = cyc + 1;
    tick();
    distance_valid = 1'b0;
  endtask

  task automatic wait_fd(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (fd_count >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (tx_enable !== 1'b0) begin failures++; $display("FAIL reset_tx_enable got=%b exp=0", tx_enable); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%02h exp=00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame(input logic [15:0] d);
    string want, got;
    int fd0, bad;
    bit ok;
    rx.delete(); rise.delete();
    fd0 = fd_count; unstable = 0; busy_at_fd = 0;
    start(d);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_accept d=%0d got=%b exp=1", d, busy); end
    wait_fd(fd0 + 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL frame_timeout d=%0d got=no frame_done exp=frame_done", d); end
    tick(); tick();
    want = s_hex(model_frame(d, 1'b1));
    got  = q_hex(rx);
    checks++; if (got != want) begin failures++; $display("FAIL frame_bytes d=%0d got=%s exp=%s", d, got, want); end
    checks++;
    if (rise.size() == 0 || rise[0] - acc_cyc != 17) begin
      failures++;
      $display("FAIL first_enable_latency d=%0d got=%0d exp=17", d, (rise.size() == 0) ? -1 : rise[0] - acc_cyc);
    end
    bad = 0;
    for (int i = 1; i < rise.size(); i++) if (rise[i] - rise[i-1] != 12) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL enable_gap d=%0d got=%0d bad gaps exp=0", d, bad); end
    checks++; if (fd_count - fd0 != 1) begin failures++; $display("FAIL frame_done_count d=%0d got=%0d exp=1", d, fd_count - fd0); end
    checks++; if (busy_at_fd != 0) begin failures++; $display("FAIL busy_with_frame_done d=%0d got=%0d exp=0", d, busy_at_fd); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL tx_data_stable d=%0d got=%0d changes exp=0", d, unstable); end
  endtask

  task automatic test_suppress_off(input logic [15:0] d);
    string want, got;
    int fd0;
    bit ok;
    rx_nz.delete();
    fd0 = fd_nz;
    distance = d;
    distance_valid_nz = 1'b1;
    tick();
    distance_valid_nz = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (fd_nz > fd0) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin failures++; $display("FAIL nz_frame_timeout d=%0d got=no frame_done exp=frame_done", d); end
    tick(); tick();
    want = s_hex(model_frame(d, 1'b0));
    got  = q_hex(rx_nz);
    checks++; if (got != want) begin failures++; $display("FAIL nz_frame_bytes d=%0d got=%s exp=%s", d, got, want); end
  endtask

  task automatic test_back_to_back();
    string want, got;
    int fd0, idx7;
    bit ok;
    rx.delete(); rise.delete();
    fd0 = fd_count;
    start(16'd42);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rx.size() >= 2) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin failures++; $display("FAIL b2b_second_byte_timeout got=%0d bytes exp=2", rx.size()); end
    distance = 16'd999;
    distance_valid = 1'b1;
    tick();
    distance_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_during_send got=%b exp=1", busy); end
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (frame_done === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok || busy !== 1'b0) begin failures++; $display("FAIL b2b_done_cycle got=done:%b busy:%b exp=done:1 busy:0", ok, busy); end
    distance = 16'd7;
    distance_valid = 1'b1;
    acc_cyc = cyc + 1;
    tick();
    distance_valid = 1'b0;
    wait_fd(fd0 + 2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_frame_timeout got=%0d frames exp=2", fd_count - fd0); end
    tick(); tick();
    want = s_hex({model_frame(42, 1'b1), model_frame(7, 1'b1)});
    got  = q_hex(rx);
    checks++; if (got != want) begin failures++; $display("FAIL b2b_bytes got=%s exp=%s", got, want); end
    idx7 = 4;
    checks++;
    if (rise.size() <= idx7 || rise[idx7] - acc_cyc != 17) begin
      failures++;
      $display("FAIL b2b_second_latency got=%0d exp=17", (rise.size() <= idx7) ? -1 : rise[idx7] - acc_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int fd0;
    bit ok;
    rx.delete(); rise.delete();
    fd0 = fd_count;
    start(16'd1234);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rx.size() >= 3 && tx_enable === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin failures++; $display("FAIL mid_reset_third_byte_timeout got=%0d bytes exp=3", rx.size()); end
    rst_n = 1'b0;
    tick();
    checks++; if (tx_enable !== 1'b0) begin failures++; $display("FAIL mid_reset_tx_enable got=%b exp=0", tx_enable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_reset_tx_data got=%02h exp=00", tx_data); end
    rst_n = 1'b1;
    repeat (40) tick();
    checks++; if (rx.size() != 3) begin failures++; $display("FAIL mid_reset_no_more_bytes got=%0d exp=3", rx.size()); end
    checks++; if (fd_count != fd0) begin failures++; $display("FAIL mid_reset_no_frame_done got=%0d exp=0", fd_count - fd0); end
    checks++; if (tx_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset_idle got=en:%b busy:%b exp=en:0 busy:0", tx_enable, busy); end
  endtask

  task automatic test_spurious();
    string want, got;
    int fd0;
    bit ok;
    spurious_req = 1'b1;
    tick(); tick();
    checks++; if (tx_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL spurious_idle got=en:%b busy:%b exp=en:0 busy:0", tx_enable, busy); end
    rx.delete(); rise.delete();
    fd0 = fd_count;
    start(16'd5);
    repeat (5) tick();
    spurious_req = 1'b1;
    tick(); tick();
    checks++; if (tx_enable !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL spurious_convert got=en:%b busy:%b exp=en:0 busy:1", tx_enable, busy); end
    wait_fd(fd0 + 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL spurious_frame_timeout got=no frame_done exp=frame_done"); end
    tick(); tick();
    want = s_hex(model_frame(5, 1'b1));
    got  = q_hex(rx);
    checks++; if (got != want) begin failures++; $display("FAIL spurious_bytes got=%s exp=%s", got, want); end
    checks++;
    if (rise.size() == 0 || rise[0] - acc_cyc != 17) begin
      failures++;
      $display("FAIL spurious_latency got=%0d exp=17", (rise.size() == 0) ? -1 : rise[0] - acc_cyc);
    end
  endtask

  initial begin : main
    test_reset();
    test_frame(16'd1234);
    test_frame(16'd0);
    test_frame(16'd65535);
    test_frame(16'd10000);
    for (int n = 0; n < 6; n++) test_frame(16'($urandom_range(0, 65535)));
    test_frame(16'($urandom_range(0, 99)));
    test_suppress_off(16'd0);
    test_suppress_off(16'd65535);
    test_suppress_off(16'($urandom_range(0, 999)));
    test_back_to_back();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/range_ascii_framer.md
Name: range_ascii_framer

Overview:
- Sits directly upstream of the UART transmitter (clk/enable/data/done interface, 8-bit data).
- Accepts a 16-bit distance measurement from the range-sensor measurement core and converts it to decimal ASCII with a sequential double-dabble.
- Sends the digits through the transmitter's enable/done handshake, followed by CR LF.
- The output is a human-readable line per measurement, e.g. "1234\r\n".

Parameters:
- SUPPRESS_ZEROS, 1: 1 = omit leading zeros (the least-significant digit is always sent); 0 = always send 5 digits.
- SEND_CRLF, 1: 1 = append 0x0D 0x0A after the digits; 0 = digits only.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- distance  input  16  unsigned measurement (0..65535); sampled only when accepted.
- distance_valid  input  1  one-cycle strobe; accepted only when busy=0.
- tx_done  input  1  one-cycle pulse from the transmitter: the current byte has finished.
- tx_enable  output  1  request to the transmitter; held high until tx_done.
- tx_data  output  8  byte to transmit; stable whenever tx_enable=1.
- busy  output  1  high from acceptance until the frame completes.
- frame_done  output  1  one-cycle pulse after the last byte's tx_done.

Behaviour:
- Reset:
  - Applies on any rising edge with rst_n=0, including mid-conversion or mid-send.
  - tx_enable=0, tx_data=0x00, busy=0, frame_done=0, FSM=IDLE; BCD and shift registers cleared.
  - An in-flight frame is abandoned and never resumed.
- IDLE:
  - distance_valid=1 at edge E: capture distance, clear the 20-bit BCD register, busy=1 after E, go to CONVERT.
  - distance_valid while busy=1 is ignored; there is no queueing.
- CONVERT:
  - 16 iterations, one per clock.
  - Each iteration: every BCD nibble >=5 gets +3, then {bcd, bin} shifts left 1.
  - Complete at edge E+16; go to SELECT.
- SELECT (one cycle):
  - Determine the first digit index. With SUPPRESS_ZEROS=1 this is the most-significant nonzero nibble; if all nibbles are zero, index 0.
  - Set tx_data = 0x30 + nibble, tx_enable=1. Both are visible after edge E+17.
- WAIT_DONE:
  - tx_enable and tx_data held constant.
  - On tx_done=1: tx_enable=0 at the next edge.
  - If more bytes remain, go to GAP; else go to FINISH.
- GAP (exactly one cycle, tx_enable=0):
  - Load the next byte (next lower digit, then 0x0D, then 0x0A).
  - Assert tx_enable and return to WAIT_DONE.
  - Enable is low for exactly one cycle between bytes.
- FINISH:
  - frame_done=1 for one cycle; busy=0 in the same cycle; go to IDLE.
  - distance_valid in the frame_done cycle is accepted, because busy=0.
- Byte order is most-significant digit first, then CR, then LF.
- tx_done while tx_enable=0 is ignored in all states.
- Frame length ranges from 1 byte (single digit, no CRLF) to 7 bytes (5 digits plus CRLF).
- Counters: a 5-bit iteration counter (0..15) and a 3-bit byte index; neither may wrap past its terminal value.

Test Plan:
- Model: a transmitter that pulses tx_done 10 cycles after sampling tx_enable=1.
- distance=1234, valid pulse -> bytes 0x31 0x32 0x33 0x34 0x0D 0x0A. First tx_enable rises 17 cycles after the accepting edge. tx_enable is low exactly one cycle between bytes. frame_done pulses once; busy falls with it.
- distance=0 -> bytes 0x30 0x0D 0x0A only. Repeat with SUPPRESS_ZEROS=0 -> 0x30 0x30 0x30 0x30 0x30 0x0D 0x0A.
- distance=65535 -> 0x36 0x35 0x35 0x33 0x35 0x0D 0x0A. distance=10000 -> 0x31 0x30 0x30 0x30 0x30 0x0D 0x0A (interior zeros kept).
- distance=42, then a second valid with 999 during the send of byte 2 -> only "42\r\n" is sent. A valid asserted in the frame_done cycle with 7 -> "7\r\n" follows.
- rst_n=0 for one cycle while tx_enable=1 on the third byte of 1234 -> after that edge tx_enable=0, busy=0, tx_data=0x00. No further bytes are sent, even if a stale tx_done arrives afterwards.
- Spurious tx_done in IDLE and during CONVERT -> no state change, no tx_enable, output for a subsequent 5 is still "5\r\n".
